// File: rtl/gshare_predictor_pkg.sv
// Shared types and helpers for the gshare branch predictor: the 2-bit
// direction counter, its saturating step functions and the PC alignment.
package gshare_predictor_pkg;

    localparam int PC_ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        PRED_SNT = 2'b00,
        PRED_WNT = 2'b01,
        PRED_WT  = 2'b10,
        PRED_ST  = 2'b11
    } prediction_t;

    function automatic prediction_t sat_inc(input prediction_t c);
        return (c == PRED_ST) ? PRED_ST : prediction_t'(c + 2'd1);
    endfunction

    function automatic prediction_t sat_dec(input prediction_t c);
        return (c == PRED_SNT) ? PRED_SNT : prediction_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side lookup and resolve-side update bundle for gshare_predictor.
// master: the pipeline (fetch + branch resolution); slave: the predictor.
interface gshare_predictor_if #(
    parameter int HIST_BITS = 4
);
    logic                 pred_valid;
    logic [31:0]          pc_fetch;
    logic                 pred_hit;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic [HIST_BITS-1:0] pred_ghr;

    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic [HIST_BITS-1:0] upd_ghr;
    logic                 upd_taken;
    logic [31:0]          upd_target;
    logic                 upd_mispredict;

    modport master (
        output pred_valid, pc_fetch,
        input  pred_hit, pred_taken, pred_target, pred_ghr,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict
    );

    modport slave (
        input  pred_valid, pc_fetch,
        output pred_hit, pred_taken, pred_target, pred_ghr,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict
    );
endinterface

// File: rtl/gshare_entry_array.sv
// Direct-mapped field array with per-entry valid bit. One synchronous write
// port; two combinational read ports, one for the fetch lookup and one for
// the read-modify-write on the update side. Valid bits clear synchronously
// on rst; data contents are never reset.
module gshare_entry_array #(
    parameter int WIDTH    = 8,
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [WIDTH-1:0]    rd_data,
    input  logic [IDX_BITS-1:0] lk_idx,
    output logic                lk_valid,
    output logic [WIDTH-1:0]    lk_data,
    input  logic                we,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [WIDTH-1:0]    wr_data
);
    localparam int DEPTH = 1 << IDX_BITS;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    // Valid bits: cleared on reset, set by any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Data storage: written only outside reset, never cleared.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Combinational reads return pre-write contents within the cycle.
    always_comb begin
        rd_valid = valid[rd_idx];
        rd_data  = mem[rd_idx];
        lk_valid = valid[lk_idx];
        lk_data  = mem[lk_idx];
    end
endmodule

// File: rtl/gshare_predictor.sv
// gshare branch predictor: PC XOR global history indexes a table of 2-bit
// counters and targets. GHR shifts speculatively on predicted fetches and is
// restored from the carried checkpoint on a mispredict.
// Optional tag checking is enabled by defining GSHARE_TAG_CHECK_EN.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int IDX_BITS  = 6,
    parameter int HIST_BITS = 4,
    parameter int TAG_BITS  = 8
) (
    input logic              clk,
    input logic              rst,
    gshare_predictor_if.slave bus
);
    localparam int IDX_LO = PC_ALIGN_BITS;
    localparam int IDX_HI = IDX_BITS + PC_ALIGN_BITS - 1;
    localparam int TAG_LO = IDX_BITS + PC_ALIGN_BITS;
    localparam int TAG_HI = IDX_BITS + TAG_BITS + PC_ALIGN_BITS - 1;

    if (HIST_BITS < 1 || HIST_BITS > IDX_BITS || TAG_BITS < 1) begin : g_bad_params
        $error("gshare_predictor: need 1 <= HIST_BITS <= IDX_BITS and TAG_BITS >= 1");
    end

    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] ghr_restore;
    logic [HIST_BITS-1:0] ghr_spec;
    logic [IDX_BITS-1:0]  rd_idx;
    logic [IDX_BITS-1:0]  wr_idx;

    logic                 upd_en;
    logic                 upd_hit;
    logic                 rd_tag_ok;
    logic                 lk_tag_ok;

    logic                 cnt_rd_valid, cnt_lk_valid;
    logic [1:0]           cnt_rd, cnt_lk;
    prediction_t          cnt_wr;
    logic                 tgt_rd_valid, tgt_lk_valid;
    logic [31:0]          tgt_rd, tgt_lk, tgt_wr;
    logic                 tgt_we;

    // Table indices: read side uses the live GHR, write side the checkpoint.
    always_comb begin
        rd_idx = bus.pc_fetch[IDX_HI:IDX_LO] ^ IDX_BITS'(ghr);
        wr_idx = bus.upd_pc[IDX_HI:IDX_LO]   ^ IDX_BITS'(bus.upd_ghr);
        upd_en = bus.upd_valid & ~rst;
    end

    gshare_entry_array #(.WIDTH(2), .IDX_BITS(IDX_BITS)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (cnt_rd_valid),
        .rd_data  (cnt_rd),
        .lk_idx   (wr_idx),
        .lk_valid (cnt_lk_valid),
        .lk_data  (cnt_lk),
        .we       (upd_en),
        .wr_idx   (wr_idx),
        .wr_data  (cnt_wr)
    );

    gshare_entry_array #(.WIDTH(32), .IDX_BITS(IDX_BITS)) u_tgt (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (tgt_rd_valid),
        .rd_data  (tgt_rd),
        .lk_idx   (wr_idx),
        .lk_valid (tgt_lk_valid),
        .lk_data  (tgt_lk),
        .we       (tgt_we),
        .wr_idx   (wr_idx),
        .wr_data  (tgt_wr)
    );

`ifdef GSHARE_TAG_CHECK_EN
    logic                tag_rd_valid, tag_lk_valid;
    logic [TAG_BITS-1:0] tag_rd, tag_lk;

    // On a hit the stored tag equals the written one, so rewriting is harmless.
    gshare_entry_array #(.WIDTH(TAG_BITS), .IDX_BITS(IDX_BITS)) u_tag (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (tag_rd_valid),
        .rd_data  (tag_rd),
        .lk_idx   (wr_idx),
        .lk_valid (tag_lk_valid),
        .lk_data  (tag_lk),
        .we       (upd_en),
        .wr_idx   (wr_idx),
        .wr_data  (bus.upd_pc[TAG_HI:TAG_LO])
    );

    // Tag compare for both the fetch lookup and the update lookup.
    always_comb begin
        rd_tag_ok = tag_rd_valid && (tag_rd == bus.pc_fetch[TAG_HI:TAG_LO]);
        lk_tag_ok = tag_lk_valid && (tag_lk == bus.upd_pc[TAG_HI:TAG_LO]);
    end
`else
    // Without tags any valid entry hits; aliasing PCs share training.
    always_comb begin
        rd_tag_ok = 1'b1;
        lk_tag_ok = 1'b1;
    end
`endif

    // Update: train a hit entry, or allocate fresh on invalid/tag mismatch.
    // A hit with an unchanged target skips the redundant target write.
    always_comb begin
        upd_hit = cnt_lk_valid & tgt_lk_valid & lk_tag_ok;
        if (upd_hit) begin
            cnt_wr = bus.upd_taken ? sat_inc(prediction_t'(cnt_lk))
                                   : sat_dec(prediction_t'(cnt_lk));
        end else begin
            cnt_wr = bus.upd_taken ? PRED_WT : PRED_WNT;
        end
        tgt_wr = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
        tgt_we = upd_en & (~upd_hit | (bus.upd_taken & (tgt_lk != bus.upd_target)));
    end

    // Prediction outputs, combinational from pc_fetch and the registered GHR.
    always_comb begin
        bus.pred_hit    = cnt_rd_valid & tgt_rd_valid & rd_tag_ok;
        bus.pred_taken  = bus.pred_hit & cnt_rd[1];
        bus.pred_target = bus.pred_taken ? tgt_rd : bus.pc_fetch + 32'd4;
        bus.pred_ghr    = ghr;
    end

    if (HIST_BITS == 1) begin : g_hist1
        // Single-bit history simply records the latest outcome.
        always_comb begin
            ghr_restore = bus.upd_taken;
            ghr_spec    = bus.pred_taken;
        end
    end else begin : g_histn
        // Shift the new outcome into the LSB of the history.
        always_comb begin
            ghr_restore = {bus.upd_ghr[HIST_BITS-2:0], bus.upd_taken};
            ghr_spec    = {ghr[HIST_BITS-2:0], bus.pred_taken};
        end
    end

    // GHR: mispredict restore beats the same-cycle speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (bus.upd_valid && bus.upd_mispredict) begin
            ghr <= ghr_restore;
        end else if (bus.pred_valid && bus.pred_hit) begin
            ghr <= ghr_spec;
        end
    end
endmodule
